// File: rtl/cvr_pkg.sv
// Shared types and defaults for the setpoint ramp selector.
package cvr_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RAMP_UP,
        RAMP_DOWN,
        HOLD
    } ramp_state_t;

    localparam int DEFAULT_WIDTH = 12;

endpackage

// File: rtl/ramp_tick_gen.sv
// Modulo-RAMP_DIV counter that issues a one-cycle tick on its last count.
module ramp_tick_gen #(
    parameter int RAMP_DIV = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic tick
);

    localparam int CNT_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(RAMP_DIV - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (run) begin
            count <= (count == LAST) ? '0 : count + 1'b1;
        end
    end

    assign tick = run && (count == LAST);

endmodule

// File: rtl/setpoint_ramp_selector.sv
// Preset bank with selectable target and a rate-limited setpoint that slews toward it.
module setpoint_ramp_selector
    import cvr_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int N_SP     = 8,
    parameter int SEL_W    = $clog2(N_SP),
    parameter int RAMP_DIV = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [SEL_W-1:0] wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [SEL_W-1:0] sel,
    input  logic             sel_valid,
    input  logic [WIDTH-1:0] step,
    input  logic             enable,
    output logic [WIDTH-1:0] setpoint,
    output logic [WIDTH-1:0] target,
    output logic             settled,
    output logic             sel_err
);

    localparam logic [SEL_W:0] N_SP_L = (SEL_W + 1)'(N_SP);

    logic [WIDTH-1:0] preset [N_SP];
    logic [SEL_W-1:0] cur_idx;
    logic             tracking;
    ramp_state_t      state, state_next;
    logic [WIDTH-1:0] target_next, setpoint_next;
    logic             wr_ok, sel_ok, wr_bad, sel_bad;
    logic             tick, tick_clear, tick_run, is_ramp;
    logic signed [WIDTH:0] diff;
    logic [WIDTH:0]   mag;
    logic             diff_pos, diff_neg, step_fits;

    assign wr_ok   = wr_en && ({1'b0, wr_addr} < N_SP_L);
    assign sel_ok  = sel_valid && ({1'b0, sel} < N_SP_L);
    assign wr_bad  = wr_en && !wr_ok;
    assign sel_bad = sel_valid && !sel_ok;

    assign diff      = $signed({1'b0, target}) - $signed({1'b0, setpoint});
    assign diff_neg  = diff[WIDTH];
    assign diff_pos  = !diff[WIDTH] && (diff != '0);
    assign mag       = diff_neg ? -diff : diff;
    assign step_fits = (step == '0) || (mag <= {1'b0, step});

    assign is_ramp    = (state == RAMP_UP) || (state == RAMP_DOWN);
    assign tick_run   = is_ramp && enable;
    assign tick_clear = !is_ramp && enable && (diff_pos || diff_neg);

    ramp_tick_gen #(.RAMP_DIV(RAMP_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (tick_clear),
        .run   (tick_run),
        .tick  (tick)
    );

    // A same-index write wins over the stale preset; otherwise a write to the tracked index follows through.
    always_comb begin
        target_next = target;
        if (sel_ok) begin
            target_next = (wr_ok && (wr_addr == sel)) ? wr_data : preset[sel];
        end else if (wr_ok && tracking && (wr_addr == cur_idx)) begin
            target_next = wr_data;
        end
    end

    always_comb begin
        state_next    = state;
        setpoint_next = setpoint;
        unique case (state)
            IDLE, HOLD: begin
                if (!enable)       state_next = HOLD;
                else if (diff_pos) state_next = RAMP_UP;
                else if (diff_neg) state_next = RAMP_DOWN;
                else               state_next = IDLE;
            end
            RAMP_UP, RAMP_DOWN: begin
                if (!enable) begin
                    state_next = HOLD;
                end else if (tick && step_fits) begin
                    setpoint_next = target;
                    state_next    = IDLE;
                end else if (!diff_pos && !diff_neg) begin
                    state_next = IDLE;
                end else begin
                    // Direction follows the live target, so a mid-ramp change reverses without losing cadence.
                    if (tick) setpoint_next = diff_neg ? setpoint - step : setpoint + step;
                    state_next = diff_neg ? RAMP_DOWN : RAMP_UP;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            target   <= '0;
            setpoint <= '0;
            settled  <= 1'b1;
            sel_err  <= 1'b0;
            cur_idx  <= '0;
            tracking <= 1'b0;
            for (int i = 0; i < N_SP; i++) preset[i] <= '0;
        end else begin
            state    <= state_next;
            target   <= target_next;
            setpoint <= setpoint_next;
            settled  <= (setpoint_next == target_next);
            sel_err  <= sel_bad || wr_bad;
            if (sel_ok) begin
                cur_idx  <= sel;
                tracking <= 1'b1;
            end
            if (wr_ok) preset[wr_addr] <= wr_data;
        end
    end

endmodule

// File: doc/setpoint_ramp_selector.md
# setpoint_ramp_selector

Parametrised successor to the fixed 8-way 12-bit setpoint multiplexer. The block holds a writable bank of N_SP preset setpoints and latches a selected preset as the target. It slews its output setpoint toward that target by a programmable step every RAMP_DIV clocks, so the regulator never sees a step change. It sits between the front-panel/host control logic and the regulator's error/PID stage.

## Interface
- WIDTH, 12, setpoint/preset width in bits (unsigned)
- N_SP, 8, number of presets; any value from 2 to 256, not necessarily a power of two
- SEL_W, $clog2(N_SP), index width
- RAMP_DIV, 16, clocks per ramp step; minimum 1
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  preset write strobe
- wr_addr  in  SEL_W  preset index to write
- wr_data  in  WIDTH  preset value
- sel  in  SEL_W  preset index to select
- sel_valid  in  1  one-cycle strobe; latches preset[sel] as target
- step  in  WIDTH  maximum change per ramp tick; 0 = jump directly
- enable  in  1  ramp enable; low freezes setpoint
- setpoint  out  WIDTH  slewed setpoint to the regulator
- target  out  WIDTH  currently latched target
- settled  out  1  high when setpoint == target
- sel_err  out  1  one-cycle pulse on out-of-range sel or wr_addr (index ≥ N_SP)

## Operation
- Reset values: all presets 0, target 0, setpoint 0, settled 1, sel_err 0, state IDLE, tick counter 0.
- Preset write: wr_en with wr_addr < N_SP updates preset[wr_addr] at the clock edge. wr_addr ≥ N_SP is ignored and pulses sel_err.
- Select: sel_valid with sel < N_SP loads target ← preset[sel]. sel ≥ N_SP leaves target unchanged and pulses sel_err.
- Live tracking: if preset[current index] is rewritten while selected, target follows on the same edge. The current index is the last accepted sel.
- Simultaneous events:
  - wr_en and sel_valid to the same index: target takes wr_data.
  - Both indices out of range: a single sel_err pulse.
- States: IDLE, RAMP_UP, RAMP_DOWN, HOLD.
  - IDLE: setpoint == target. target > setpoint → RAMP_UP; target < setpoint → RAMP_DOWN.
  - RAMP_UP / RAMP_DOWN: on each tick, diff = target − setpoint is computed as a WIDTH+1-bit signed value.
    - If |diff| ≤ step, or step == 0: setpoint ← target, go to IDLE.
    - Otherwise setpoint ± step.
    - If target changes mid-ramp, direction is re-evaluated on the next edge.
  - HOLD: entered from any state when enable = 0. Setpoint and tick counter are frozen; target and presets still update. When enable = 1, go to IDLE if equal, otherwise to the appropriate RAMP state.
- Arithmetic never wraps; setpoint always stays within [min(old, target), max(old, target)].
- settled = (setpoint == target), registered, so it is valid in the same cycle as setpoint.

## Timing
- sel_valid accepted at edge t: target valid after edge t. State leaves IDLE at edge t+1.
- Tick counter clears on entering a RAMP state. The first step is applied at edge t+1+RAMP_DIV, then one step every RAMP_DIV clocks.
- step == 0: setpoint equals target at edge t+1+RAMP_DIV (single tick).
- sel_err is asserted for exactly the cycle following the offending strobe.
- Asynchronous reset asserted mid-ramp: all registers return to reset values immediately.

## Structure
- Package cvr_pkg holds:
  - ramp state enum {IDLE, RAMP_UP, RAMP_DOWN, HOLD}
  - default WIDTH constant (12)
- Sub-module ramp_tick_gen, parameter RAMP_DIV, inputs clk/rst_n/clear/run, output tick. It is a modulo-RAMP_DIV counter with a one-cycle tick when the count reaches RAMP_DIV−1.
- The preset bank is a register array, not RAM, so reset and same-edge tracking work.

## Test plan
- Reset, write preset[3]=0x800, select 3, step=0x100, RAMP_DIV=4 → setpoint rises 0x100 every 4 clocks; reaches 0x800 after 8 ticks; settled rises with the final value.
- From 0x800, select preset 0 (=0x0F0), step=0x300 → setpoint goes 0x500, 0x200, then clamps to 0x0F0 with no undershoot.
- N_SP=6, sel_valid with sel=7 → target unchanged, one-cycle sel_err; wr_addr=6 write ignored with sel_err.
- Mid-ramp, rewrite the selected preset below the current setpoint → direction reverses on the next tick; final setpoint equals the new value.
- enable low for 20 clocks mid-ramp → setpoint constant, no ticks; resumes with the first step RAMP_DIV clocks after enable returns high.
- Assert rst_n low mid-ramp for 1 clock → setpoint=0, target=0, settled=1 immediately; no step is applied after release until a new sel_valid.
